ofmap_drain: RTL and testbench

Output-side reader for the coprocessor's subblock SRAM. While the coprocessor controller is in its OUTPUT state (`sendOutput` high), this block walks every accumulated ofmap pixel in block → ofmap → X → Y order. It issues one read per element on the SRAM read port and streams the returned bytes out over a valid/ready interface. It raises `cumulationDone` to release the controller back to IDLE.

---
 rtl/coproc_pkg.sv | 18 +
 rtl/ofmap_drain_fifo2.sv | 54 +++++
 rtl/ofmap_drain.sv | 198 +++++++++++++++++++
 tb/tb_ofmap_drain.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// Shared coprocessor definitions: default datapath/address widths (also used by
// subblockSRAM and cpState) and the ofmap drain state encoding.
package coproc_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_BLK_W  = 5;
    localparam int DEF_OFM_W  = 5;
    localparam int DEF_PIX_W  = 6;

    // Drain sequencer states
    typedef enum logic [1:0] {
        DR_IDLE  = 2'd0,
        DR_READ  = 2'd1,
        DR_FLUSH = 2'd2,
        DR_DONE  = 2'd3
    } drain_state_e;

endpackage

// File: rtl/ofmap_drain_fifo2.sv
// Two-entry FIFO between the SRAM read port and the output stream.
// The head entry is always visible on o_head; pop and push may happen in the
// same cycle even when full, since the caller only pushes into freed space.
module drain_fifo2 #(
    parameter int W = 9
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem0;
    logic [W-1:0] r_mem1;
    logic         r_rdPtr;
    logic         r_wrPtr;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign w_push  = i_push && ((r_count != 2'd2) || w_pop);
    assign o_head  = r_rdPtr ? r_mem1 : r_mem0;
    assign o_count = r_count;

    // Pointer and occupancy tracking; flush empties the FIFO without touching storage
    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_rdPtr <= 1'b0;
            r_wrPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_wrPtr <= ~r_wrPtr;
            if (w_pop)  r_rdPtr <= ~r_rdPtr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Storage; cleared on reset so the stream data output reads zero afterwards
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem0 <= '0;
            r_mem1 <= '0;
        end else if (w_push && !i_flush) begin
            if (r_wrPtr) r_mem1 <= i_data;
            else         r_mem0 <= i_data;
        end
    end

endmodule

// File: rtl/ofmap_drain.sv
// Ofmap drain: walks every accumulated pixel in block/ofmap/X/Y order while the
// controller sits in OUTPUT, reads each from the subblock SRAM and streams the
// bytes out over valid/ready, then pulses cumulationDone.
module ofmap_drain
    import coproc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BLK_W  = DEF_BLK_W,
    parameter int OFM_W  = DEF_OFM_W,
    parameter int PIX_W  = DEF_PIX_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sendOutput,
    input  logic [BLK_W-1:0]  cfgBlocks,
    input  logic [OFM_W-1:0]  cfgOfmaps,
    input  logic [PIX_W-1:0]  cfgX,
    input  logic [PIX_W-1:0]  cfgY,
    output logic              sramCS,
    output logic              sramRD,
    output logic              sramWE,
    output logic [BLK_W-1:0]  sramBlock,
    output logic [OFM_W-1:0]  sramOfmap,
    output logic [PIX_W-1:0]  sramX,
    output logic [PIX_W-1:0]  sramY,
    input  logic [DATA_W-1:0] sramData,
    output logic [DATA_W-1:0] outData,
    output logic              outValid,
    input  logic              outReady,
    output logic              outLast,
    output logic              cumulationDone
);

    drain_state_e      r_state;
    drain_state_e      w_nextState;

    logic              r_sendPrev;
    logic              w_start;

    logic [BLK_W-1:0]  r_cfgBlk;
    logic [OFM_W-1:0]  r_cfgOfm;
    logic [PIX_W-1:0]  r_cfgX;
    logic [PIX_W-1:0]  r_cfgY;

    logic [BLK_W-1:0]  r_blk;
    logic [OFM_W-1:0]  r_ofm;
    logic [PIX_W-1:0]  r_x;
    logic [PIX_W-1:0]  r_y;
    logic              w_lastAddr;

    logic              r_inFlight;
    logic              r_inFlightLast;

    logic [DATA_W:0]   w_head;
    logic [1:0]        w_fifoCount;
    logic [2:0]        w_occ;
    logic              w_flush;

    logic              w_active;
    logic              w_valid;
    logic              w_pop;
    logic              w_issue;
    logic              w_done;

    assign w_start    = sendOutput && !r_sendPrev;
    assign w_lastAddr = (r_blk == r_cfgBlk) && (r_ofm == r_cfgOfm) &&
                        (r_x == r_cfgX) && (r_y == r_cfgY);
    // Elements already committed to the stream: buffered plus the read in flight
    assign w_occ      = {1'b0, w_fifoCount} + {2'b00, r_inFlight};
    // Anything left over from an aborted drain is dropped while idle
    assign w_flush    = (r_state == DR_IDLE);

    // Registered copy of sendOutput for edge detection; tracks the input even
    // during reset so an edge that lands in reset is swallowed
    always_ff @(posedge clock) begin
        r_sendPrev <= sendOutput;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= DR_IDLE;
        else       r_state <= w_nextState;
    end

    // Next-state logic; dropping sendOutput mid-drain aborts straight to IDLE
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            DR_IDLE: begin
                if (w_start) w_nextState = DR_READ;
            end
            DR_READ: begin
                if (!sendOutput)                w_nextState = DR_IDLE;
                else if (w_issue && w_lastAddr) w_nextState = DR_FLUSH;
            end
            DR_FLUSH: begin
                if (!sendOutput)                w_nextState = DR_IDLE;
                else if (w_pop && w_head[DATA_W]) w_nextState = DR_DONE;
            end
            DR_DONE: begin
                w_nextState = DR_IDLE;
            end
            default: w_nextState = DR_IDLE;
        endcase
    end

    // Output decode. A read may issue whenever the FIFO is guaranteed a slot for
    // its data, counting the slot freed by a pop this same cycle so that a
    // continuously ready sink sees one element per cycle.
    always_comb begin
        w_active = (r_state == DR_READ) || (r_state == DR_FLUSH);
        w_valid  = w_active && (w_fifoCount != 2'd0);
        w_pop    = w_valid && outReady;
        w_issue  = (r_state == DR_READ) &&
                   ((w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop));
        w_done   = (r_state == DR_DONE);
    end

    // Drain geometry is frozen at the start edge so cfg may change mid-drain
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cfgBlk <= '0;
            r_cfgOfm <= '0;
            r_cfgX   <= '0;
            r_cfgY   <= '0;
        end else if ((r_state == DR_IDLE) && w_start) begin
            r_cfgBlk <= cfgBlocks;
            r_cfgOfm <= cfgOfmaps;
            r_cfgX   <= cfgX;
            r_cfgY   <= cfgY;
        end
    end

    // Cascaded address counters: Y fastest, carrying into X, ofmap, then block
    always_ff @(posedge clock) begin
        if (reset || ((r_state == DR_IDLE) && w_start)) begin
            r_blk <= '0;
            r_ofm <= '0;
            r_x   <= '0;
            r_y   <= '0;
        end else if (w_issue) begin
            if (r_y == r_cfgY) begin
                r_y <= '0;
                if (r_x == r_cfgX) begin
                    r_x <= '0;
                    if (r_ofm == r_cfgOfm) begin
                        r_ofm <= '0;
                        if (r_blk != r_cfgBlk) r_blk <= r_blk + 1'b1;
                    end else begin
                        r_ofm <= r_ofm + 1'b1;
                    end
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end else begin
                r_y <= r_y + 1'b1;
            end
        end
    end

    // One-deep read pipeline: the issued read returns data next cycle, carrying
    // the last-element tag alongside it; an aborting cycle's read is discarded
    always_ff @(posedge clock) begin
        if (reset) begin
            r_inFlight     <= 1'b0;
            r_inFlightLast <= 1'b0;
        end else begin
            r_inFlight     <= w_issue && sendOutput;
            r_inFlightLast <= w_issue && w_lastAddr;
        end
    end

    drain_fifo2 #(
        .W (DATA_W + 1)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (r_inFlight),
        .i_data  ({r_inFlightLast, sramData}),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_count (w_fifoCount)
    );

    assign sramCS         = w_issue;
    assign sramRD         = w_issue;
    assign sramWE         = 1'b0;
    assign sramBlock      = r_blk;
    assign sramOfmap      = r_ofm;
    assign sramX          = r_x;
    assign sramY          = r_y;
    assign outData        = w_head[DATA_W-1:0];
    assign outValid       = w_valid;
    assign outLast        = w_valid && w_head[DATA_W];
    assign cumulationDone = w_done;

endmodule

// File: tb/tb_ofmap_drain.sv
// Bench for ofmap_drain: table of drain configurations with expected beat
// counts and completion cycles, random drains, plus abort/reset sequences.
module tb_ofmap_drain;

    logic        clock = 1'b0;
    logic        reset;
    logic        sendOutput;
    logic [4:0]  cfgBlocks;
    logic [4:0]  cfgOfmaps;
    logic [5:0]  cfgX;
    logic [5:0]  cfgY;
    logic        sramCS;
    logic        sramRD;
    logic        sramWE;
    logic [4:0]  sramBlock;
    logic [4:0]  sramOfmap;
    logic [5:0]  sramX;
    logic [5:0]  sramY;
    logic [7:0]  sramData = 8'h00;
    logic [7:0]  outData;
    logic        outValid;
    logic        outReady;
    logic        outLast;
    logic        cumulationDone;

    logic [7:0]  seed = 8'h00;
    int          tests = 0;
    int          fails = 0;

    initial forever #5 clock = ~clock;

    ofmap_drain dut (
        .clock          (clock),
        .reset          (reset),
        .sendOutput     (sendOutput),
        .cfgBlocks      (cfgBlocks),
        .cfgOfmaps      (cfgOfmaps),
        .cfgX           (cfgX),
        .cfgY           (cfgY),
        .sramCS         (sramCS),
        .sramRD         (sramRD),
        .sramWE         (sramWE),
        .sramBlock      (sramBlock),
        .sramOfmap      (sramOfmap),
        .sramX          (sramX),
        .sramY          (sramY),
        .sramData       (sramData),
        .outData        (outData),
        .outValid       (outValid),
        .outReady       (outReady),
        .outLast        (outLast),
        .cumulationDone (cumulationDone)
    );

    // SRAM contents: linear pixel index under the current geometry, xor seed
    function automatic int lin_of(int b, int o, int x, int y);
        return ((b * (int'(cfgOfmaps) + 1) + o) * (int'(cfgX) + 1) + x) * (int'(cfgY) + 1) + y;
    endfunction

    always @(posedge clock)
        if (sramCS) sramData <= 8'(lin_of(int'(sramBlock), int'(sramOfmap), int'(sramX), int'(sramY))) ^ seed;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one full drain from a start edge. Caller leaves sendOutput low for the
    // preceding cycle and enters at #1 after a rising edge.
    task automatic run_drain(input int b, input int o, input int x, input int y,
                             input logic [7:0] sd, input int rmode,
                             input int expN, input int expDone);
        int        addrQ[$];
        int        n;
        int        beats;
        int        issues;
        int        doneCyc;
        int        firstV;
        int        c;
        int        limit;
        int        expA;
        logic      prevStall;
        logic [7:0] prevData;
        logic      prevLast;
        n = (b + 1) * (o + 1) * (x + 1) * (y + 1);
        for (int ib = 0; ib <= b; ib++)
            for (int io = 0; io <= o; io++)
                for (int ix = 0; ix <= x; ix++)
                    for (int iy = 0; iy <= y; iy++)
                        addrQ.push_back((ib << 17) | (io << 12) | (ix << 6) | iy);
        beats = 0; issues = 0; doneCyc = -1; firstV = -1; c = 0;
        limit = 4 * n + 20;
        prevStall = 1'b0; prevData = 8'h00; prevLast = 1'b0;
        cfgBlocks = 5'(b); cfgOfmaps = 5'(o); cfgX = 6'(x); cfgY = 6'(y);
        seed = sd;
        sendOutput = 1'b1;
        while (doneCyc < 0 && c < limit) begin
            case (rmode)
                0:       outReady = 1'b1;
                1:       outReady = (c % 2 == 0);
                default: outReady = ($urandom % 4 != 0);
            endcase
            @(negedge clock);
            chk("outstanding_le2", int'(issues - beats <= 2), 1);
            if (sramCS) begin
                issues++;
                if (addrQ.size() == 0) chk("extra_issue", issues, n);
                else begin
                    expA = addrQ.pop_front();
                    chk("addr", int'({sramBlock, sramOfmap, sramX, sramY}), expA);
                end
            end
            if (sramRD !== sramCS || sramWE !== 1'b0) chk("rd_we", int'({sramRD, sramWE}), int'({sramCS, 1'b0}));
            if (outValid && firstV < 0) firstV = c;
            if (outValid && prevStall) begin
                chk("stall_data", int'(outData), int'(prevData));
                chk("stall_last", int'(outLast), int'(prevLast));
            end
            if (outValid && outReady) begin
                chk("data", int'(outData), (beats & 255) ^ int'(sd));
                chk("last", int'(outLast), int'(beats == n - 1));
                beats++;
            end
            if (cumulationDone) doneCyc = c;
            prevStall = outValid && !outReady;
            prevData  = outData;
            prevLast  = outLast;
            tick();
            c++;
        end
        if (doneCyc < 0) chk("done_timeout", 0, 1);
        chk("beats", beats, expN);
        chk("issues", issues, n);
        chk("first_valid_cycle", firstV, 3);
        if (expDone >= 0) chk("done_cycle", doneCyc, expDone);
        // Holding sendOutput high after completion must not start another drain
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("no_restart", int'({cumulationDone, sramCS, outValid}), 0);
            tick();
        end
        sendOutput = 1'b0;
        tick();
    endtask

    typedef struct {
        int         b, o, x, y;
        logic [7:0] sd;
        int         rmode;
        int         expN;
        int         expDone;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int beats;
        int bad;
        int rb, ro, rx, ry;

        vecs[0] = '{0, 0, 0, 0, 8'hA5, 0,  1,  4};
        vecs[1] = '{1, 1, 1, 1, 8'h00, 0, 16, 19};
        vecs[2] = '{1, 1, 1, 1, 8'h00, 1, 16, -1};
        vecs[3] = '{0, 0, 0, 3, 8'h77, 0,  4,  7};
        vecs[4] = '{2, 1, 0, 2, 8'hC3, 2, 18, -1};
        vecs[5] = '{0, 2, 1, 0, 8'h11, 0,  6,  9};

        reset = 1'b1; sendOutput = 1'b0; outReady = 1'b1;
        cfgBlocks = '0; cfgOfmaps = '0; cfgX = '0; cfgY = '0;
        tick(); tick();
        @(negedge clock);
        chk("reset_ctl", int'({sramCS, sramRD, sramWE, outValid, outLast, cumulationDone}), 0);
        chk("reset_addr", int'({sramBlock, sramOfmap, sramX, sramY}), 0);
        chk("reset_data", int'(outData), 0);
        tick();
        reset = 1'b0;
        tick();

        foreach (vecs[i])
            run_drain(vecs[i].b, vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].sd,
                      vecs[i].rmode, vecs[i].expN, vecs[i].expDone);

        for (int r = 0; r < 6; r++) begin
            rb = $urandom_range(0, 2); ro = $urandom_range(0, 2);
            rx = $urandom_range(0, 2); ry = $urandom_range(0, 2);
            run_drain(rb, ro, rx, ry, 8'($urandom), 2,
                      (rb + 1) * (ro + 1) * (rx + 1) * (ry + 1), -1);
        end

        // Abort after 5 transfers, then confirm a fresh drain starts from zero
        cfgBlocks = 5'd1; cfgOfmaps = 5'd1; cfgX = 6'd1; cfgY = 6'd1; seed = 8'h3C;
        sendOutput = 1'b1; outReady = 1'b1; beats = 0;
        for (int c = 0; c < 40 && beats < 5; c++) begin
            @(negedge clock);
            if (outValid && outReady) beats++;
            tick();
        end
        chk("abort_beats", beats, 5);
        sendOutput = 1'b0;
        tick();
        @(negedge clock);
        chk("abort_valid", int'(outValid), 0);
        chk("abort_cs", int'(sramCS), 0);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (cumulationDone || outValid) bad++;
            tick();
        end
        chk("abort_no_done", bad, 0);
        run_drain(1, 1, 1, 1, 8'h3C, 0, 16, 19);

        // Reset during FLUSH with the sink stalled
        cfgBlocks = '0; cfgOfmaps = '0; cfgX = '0; cfgY = '0; seed = 8'h5A;
        sendOutput = 1'b1; outReady = 1'b0;
        tick(); tick(); tick();
        @(negedge clock);
        chk("flush_stall_valid", int'(outValid), 1);
        chk("flush_stall_data", int'(outData), 8'h5A);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_ctl", int'({sramCS, sramRD, sramWE, outValid, outLast, cumulationDone}), 0);
        chk("midrst_addr", int'({sramBlock, sramOfmap, sramX, sramY}), 0);
        chk("midrst_data", int'(outData), 0);
        outReady = 1'b1;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (sramCS || outValid || cumulationDone) bad++;
            tick();
        end
        chk("midrst_no_restart", bad, 0);
        sendOutput = 1'b0;
        tick();

        // Start edge coinciding with reset is ignored
        reset = 1'b1; sendOutput = 1'b1;
        tick();
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (sramCS || outValid) bad++;
            tick();
        end
        chk("rst_edge_ignored", bad, 0);
        sendOutput = 1'b0;
        tick();
        run_drain(0, 1, 0, 1, 8'h96, 1, 4, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
